regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU/execute) and req1 (LSU/load return).
- Per-requester valid/ready handshake, round-robin or fixed-priority grant, and one registered output stage that drives the register file write port.
- Forwarding outputs cover the write held in the output stage, which is not yet visible through the register file's combinational reads.
- Sits between the execute/LSU writeback buses and the register file.

Parameters:
XLEN, 32, data width of writeback values
REG_ADDR_W, 5, register address width (32 registers)
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = req0 always wins
CNT_W, 16, width of saturating conflict counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
i_req0_valid  in  1  req0 has a writeback
i_req0_addr  in  REG_ADDR_W  req0 destination register
i_req0_data  in  XLEN  req0 writeback value
o_req0_ready  out  1  req0 accepted this cycle
i_req1_valid  in  1  req1 has a writeback
i_req1_addr  in  REG_ADDR_W  req1 destination register
i_req1_data  in  XLEN  req1 writeback value
o_req1_ready  out  1  req1 accepted this cycle
o_wr_en  out  1  register file write enable
o_wr_addr  out  REG_ADDR_W  register file write address
o_wr_data  out  XLEN  register file write data
i_rd_addr1  in  REG_ADDR_W  read port 1 address (mirrors register file)
i_rd_addr2  in  REG_ADDR_W  read port 2 address
o_fwd1_hit  out  1  in-flight write matches i_rd_addr1
o_fwd2_hit  out  1  in-flight write matches i_rd_addr2
o_fwd_data  out  XLEN  in-flight write data (equals o_wr_data)
o_conflict_cnt  out  CNT_W  cycles in which both requesters were valid (saturating)

Behaviour:
- Arbitration is combinational from the valids and the state bit r_last_grant (0 = req0, 1 = req1).
- Only one valid: that requester is granted.
- Both valid, FIXED_PRIO=0: the requester not equal to r_last_grant is granted.
- Both valid, FIXED_PRIO=1: req0 is granted.
- o_reqK_ready = grant K. At most one ready is high per cycle. No ready is high without its valid.
- A handshake is valid & ready at a posedge. On a handshake, r_last_grant takes the granted index.
- Requesters hold valid, addr and data stable until ready. The arbiter does not check this.
- Output stage, updated every posedge:
  - o_wr_en <= handshake && granted addr != 0.
  - o_wr_addr/o_wr_data <= granted addr/data on a handshake; otherwise they hold.
- Latency: handshake at edge E puts the write on o_wr_* during cycle E..E+1. The register file commits it at edge E+1.
- Back-to-back acceptance (one write per cycle) has no bubbles.
- x0 destination: the request is accepted normally and r_last_grant updates, but o_wr_en stays 0 and no forwarding occurs.
- Forwarding:
  - o_fwdN_hit = o_wr_en && (o_wr_addr == i_rd_addrN), combinational.
  - o_fwd_data = o_wr_data.
  - Read address 0 never hits.
- Same address from both requesters in one cycle: the writes are serialized in grant order. The later-granted value is the final register content.
- Conflict counter: increments on each posedge where both valids are high. It saturates at 2^CNT_W-1 and does not wrap.
- Reset, taking priority over all other updates:
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0.
  - r_last_grant=1, so req0 wins the first tie.
  - o_conflict_cnt=0.
- Both readies are forced to 0 while rst=1.
- A write in flight at reset assertion is discarded: o_wr_en is 0 in the cycle after reset is sampled.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and REG_ADDR_W constants.
  - typedef wb_req_t {logic [REG_ADDR_W-1:0] addr; logic [XLEN-1:0] data;}.
  - localparam REG_ZERO = '0.
- One sub-module, rr_arbiter2: a two-input grant with last-grant state and a FIXED_PRIO parameter.
- The output stage, forwarding compare and counter stay in the top module.

Test Plan:
- Reset: hold rst 3 cycles with both valid high -> both readies 0, o_wr_en 0, o_conflict_cnt 0. After release, the first tie grants req0.
- Single requester: req0 valid addr=5 data=0xDEADBEEF -> ready same cycle, o_wr_en=1/addr=5/data=0xDEADBEEF next cycle. With i_rd_addr1=5, o_fwd1_hit=1 for exactly that one cycle.
- Contention, round-robin: both valid continuously for 4 cycles (req0 addr=1, req1 addr=2, new data each accept) -> grants alternate 0,1,0,1. o_wr_addr sequence 1,2,1,2. o_conflict_cnt=4.
- Fixed priority: FIXED_PRIO=1 with both valid for 3 cycles -> req0 granted all 3, req1 ready stays 0. Req1 is granted on the cycle req0 drops.
- x0 and same-address: req0 addr=0 is accepted with o_wr_en remaining 0. Both requesting addr=7 (data 0x11 and 0x22) -> two serialized writes, and register 7 finally holds the later-granted value.
- Saturation and mid-reset: CNT_W=4 with 20 conflict cycles -> counter holds at 15. Asserting rst in a cycle with o_wr_en=1 -> o_wr_en=0 the next cycle and counter=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V core constants and writeback request type used by the
// register file write-port arbiter and its neighbours.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is hardwired to zero, so writes addressed to it are dropped
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage : rv_pkg

// File: rtl/rr_arbiter2.sv
// Two-input grant with a remembered last winner; ties alternate unless
// FIXED_PRIO pins the win to input 0.
module rr_arbiter2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic lastGrant_q;
  logic lastGrant_d;
  logic [1:0] grant;

  always_comb begin
    grant = 2'b00;
    if (rst) begin
      grant = 2'b00;
    end else if (valid_i == 2'b11) begin
      if ((FIXED_PRIO != 0) || lastGrant_q) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else begin
      grant = valid_i;
    end
  end

  // A grant is always a completed handshake because ready mirrors grant
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (grant[0]) begin
      lastGrant_d = 1'b0;
    end else if (grant[1]) begin
      lastGrant_d = 1'b1;
    end
  end

  // Reset to 1 so that req0 wins the first tie after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

  assign grant_o = grant;

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the execute and LSU writeback
// buses, with one registered output stage and forwarding of the held write.
module regfile_wb_arbiter #(
  parameter int XLEN       = rv_pkg::XLEN,
  parameter int REG_ADDR_W = rv_pkg::REG_ADDR_W,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req0_valid,
  input  logic [REG_ADDR_W-1:0] i_req0_addr,
  input  logic [XLEN-1:0]       i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [REG_ADDR_W-1:0] i_req1_addr,
  input  logic [XLEN-1:0]       i_req1_data,
  output logic                  o_req1_ready,
  output logic                  o_wr_en,
  output logic [REG_ADDR_W-1:0] o_wr_addr,
  output logic [XLEN-1:0]       o_wr_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr1,
  input  logic [REG_ADDR_W-1:0] i_rd_addr2,
  output logic                  o_fwd1_hit,
  output logic                  o_fwd2_hit,
  output logic [XLEN-1:0]       o_fwd_data,
  output logic [CNT_W-1:0]      o_conflict_cnt
);

  import rv_pkg::*;

  logic [1:0]            grant;
  logic                  handshake;
  logic                  conflict;
  logic [REG_ADDR_W-1:0] selAddr;
  logic [XLEN-1:0]       selData;

  logic                  wrEn_q,   wrEn_d;
  logic [REG_ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [XLEN-1:0]       wrData_q, wrData_d;
  logic [CNT_W-1:0]      conflictCnt_q, conflictCnt_d;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i ({i_req1_valid, i_req0_valid}),
    .grant_o (grant)
  );

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign handshake    = |grant;
  assign conflict     = i_req0_valid & i_req1_valid;

  always_comb begin
    selAddr = i_req0_addr;
    selData = i_req0_data;
    if (grant[1]) begin
      selAddr = i_req1_addr;
      selData = i_req1_data;
    end
  end

  // x0 writes are still accepted but never raise the write enable
  always_comb begin
    wrEn_d        = handshake && (selAddr != REG_ADDR_W'(REG_ZERO));
    wrAddr_d      = wrAddr_q;
    wrData_d      = wrData_q;
    conflictCnt_d = conflictCnt_q;
    if (handshake) begin
      wrAddr_d = selAddr;
      wrData_d = selData;
    end
    if (conflict && (conflictCnt_q != {CNT_W{1'b1}})) begin
      conflictCnt_d = conflictCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrEn_q        <= 1'b0;
      wrAddr_q      <= '0;
      wrData_q      <= '0;
      conflictCnt_q <= '0;
    end else begin
      wrEn_q        <= wrEn_d;
      wrAddr_q      <= wrAddr_d;
      wrData_q      <= wrData_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign o_wr_en        = wrEn_q;
  assign o_wr_addr      = wrAddr_q;
  assign o_wr_data      = wrData_q;
  assign o_conflict_cnt = conflictCnt_q;

  // The held write is not yet in the register file, so reads must bypass it
  assign o_fwd1_hit = wrEn_q && (wrAddr_q == i_rd_addr1);
  assign o_fwd2_hit = wrEn_q && (wrAddr_q == i_rd_addr2);
  assign o_fwd_data = wrData_q;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench driving one stimulus into round-robin, fixed-priority and
// narrow-counter instances of the writeback arbiter.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0Valid, req1Valid;
  logic [4:0]  req0Addr, req1Addr;
  logic [31:0] req0Data, req1Data;
  logic [4:0]  rdAddr1, rdAddr2;

  logic        rrReady0, rrReady1, rrWrEn, rrFwd1, rrFwd2;
  logic [4:0]  rrWrAddr;
  logic [31:0] rrWrData, rrFwdData;
  logic [15:0] rrCnt;

  logic        fpReady0, fpReady1, fpWrEn, fpFwd1, fpFwd2;
  logic [4:0]  fpWrAddr;
  logic [31:0] fpWrData, fpFwdData;
  logic [15:0] fpCnt;

  logic        satReady0, satReady1, satWrEn, satFwd1, satFwd2;
  logic [4:0]  satWrAddr;
  logic [31:0] satWrData, satFwdData;
  logic [3:0]  satCnt;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] rfModel [32];

  regfile_wb_arbiter dutRr (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0Valid), .i_req0_addr(req0Addr), .i_req0_data(req0Data), .o_req0_ready(rrReady0),
    .i_req1_valid(req1Valid), .i_req1_addr(req1Addr), .i_req1_data(req1Data), .o_req1_ready(rrReady1),
    .o_wr_en(rrWrEn), .o_wr_addr(rrWrAddr), .o_wr_data(rrWrData),
    .i_rd_addr1(rdAddr1), .i_rd_addr2(rdAddr2),
    .o_fwd1_hit(rrFwd1), .o_fwd2_hit(rrFwd2), .o_fwd_data(rrFwdData),
    .o_conflict_cnt(rrCnt)
  );

  regfile_wb_arbiter #(.FIXED_PRIO(1)) dutFp (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0Valid), .i_req0_addr(req0Addr), .i_req0_data(req0Data), .o_req0_ready(fpReady0),
    .i_req1_valid(req1Valid), .i_req1_addr(req1Addr), .i_req1_data(req1Data), .o_req1_ready(fpReady1),
    .o_wr_en(fpWrEn), .o_wr_addr(fpWrAddr), .o_wr_data(fpWrData),
    .i_rd_addr1(rdAddr1), .i_rd_addr2(rdAddr2),
    .o_fwd1_hit(fpFwd1), .o_fwd2_hit(fpFwd2), .o_fwd_data(fpFwdData),
    .o_conflict_cnt(fpCnt)
  );

  regfile_wb_arbiter #(.CNT_W(4)) dutSat (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0Valid), .i_req0_addr(req0Addr), .i_req0_data(req0Data), .o_req0_ready(satReady0),
    .i_req1_valid(req1Valid), .i_req1_addr(req1Addr), .i_req1_data(req1Data), .o_req1_ready(satReady1),
    .o_wr_en(satWrEn), .o_wr_addr(satWrAddr), .o_wr_data(satWrData),
    .i_rd_addr1(rdAddr1), .i_rd_addr2(rdAddr2),
    .o_fwd1_hit(satFwd1), .o_fwd2_hit(satFwd2), .o_fwd_data(satFwdData),
    .o_conflict_cnt(satCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file contents as seen through the round-robin write port
  always @(posedge clk) begin
    if (rrWrEn) rfModel[rrWrAddr] <= rrWrData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0Valid = v0; req0Addr = a0; req0Data = d0;
    req1Valid = v1; req1Addr = a1; req1Data = d1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dat0, dat1;
  int          expG    [4] = '{0, 1, 0, 1};
  logic [4:0]  expAddr [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
  logic [31:0] expData [4] = '{32'h1000, 32'h2000, 32'h1001, 32'h2001};

  initial begin
    rst = 1'b1;
    rdAddr1 = 5'd0;
    rdAddr2 = 5'd0;
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);

    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("rst_ready0", rrReady0, 1'b0);
      checkOutput("rst_ready1", rrReady1, 1'b0);
      checkOutput("rst_wr_en", rrWrEn, 1'b0);
      checkOutput("rst_cnt", rrCnt, 16'd0);
    end

    rst  = 1'b0;
    dat0 = 32'h1000;
    dat1 = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 5'd1, dat0, 1'b1, 5'd2, dat1);
      #1;
      checkOutput("rr_ready0", rrReady0, (expG[k] == 0));
      checkOutput("rr_ready1", rrReady1, (expG[k] == 1));
      checkOutput("fp_ready0", fpReady0, 1'b1);
      checkOutput("fp_ready1", fpReady1, 1'b0);
      nextCycle();
      checkOutput("rr_wr_en", rrWrEn, 1'b1);
      checkOutput("rr_wr_addr", rrWrAddr, expAddr[k]);
      checkOutput("rr_wr_data", rrWrData, expData[k]);
      checkOutput("fp_wr_addr", fpWrAddr, 5'd1);
      if (expG[k] == 0) dat0 = dat0 + 1;
      else              dat1 = dat1 + 1;
    end
    checkOutput("rr_cnt4", rrCnt, 16'd4);
    checkOutput("fp_cnt4", fpCnt, 16'd4);
    checkOutput("sat_cnt4", satCnt, 4'd4);

    applyStimulus(1'b0, 5'd1, dat0, 1'b1, 5'd2, dat1);
    #1;
    checkOutput("fp_req1_alone", fpReady1, 1'b1);
    checkOutput("fp_req0_off", fpReady0, 1'b0);
    checkOutput("rr_req1_alone", rrReady1, 1'b1);
    nextCycle();
    checkOutput("req1_wr_addr", rrWrAddr, 5'd2);
    checkOutput("req1_wr_data", rrWrData, 32'h2002);
    checkOutput("cnt_no_conflict", rrCnt, 16'd4);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    nextCycle();
    checkOutput("idle_wr_en", rrWrEn, 1'b0);

    rdAddr1 = 5'd5;
    rdAddr2 = 5'd6;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("single_ready0", rrReady0, 1'b1);
    checkOutput("single_ready1", rrReady1, 1'b0);
    checkOutput("fwd1_before", rrFwd1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("single_wr_en", rrWrEn, 1'b1);
    checkOutput("single_wr_addr", rrWrAddr, 5'd5);
    checkOutput("single_wr_data", rrWrData, 32'hDEADBEEF);
    checkOutput("fwd1_hit", rrFwd1, 1'b1);
    checkOutput("fwd2_miss", rrFwd2, 1'b0);
    checkOutput("fwd_data", rrFwdData, 32'hDEADBEEF);
    nextCycle();
    checkOutput("fwd1_after", rrFwd1, 1'b0);
    checkOutput("single_wr_en_off", rrWrEn, 1'b0);

    rdAddr1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("x0_ready0", rrReady0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("x0_wr_en", rrWrEn, 1'b0);
    checkOutput("x0_wr_addr", rrWrAddr, 5'd0);
    checkOutput("x0_wr_data", rrWrData, 32'h55);
    checkOutput("x0_fwd1", rrFwd1, 1'b0);
    nextCycle();

    // Last grant is req0 (the x0 write), so req1 wins this tie
    rdAddr2 = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    #1;
    checkOutput("same_ready1", rrReady1, 1'b1);
    checkOutput("same_ready0", rrReady0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("same_first_en", rrWrEn, 1'b1);
    checkOutput("same_first_addr", rrWrAddr, 5'd7);
    checkOutput("same_first_data", rrWrData, 32'h22);
    checkOutput("same_fwd2", rrFwd2, 1'b1);
    checkOutput("same_ready0_2nd", rrReady0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("same_second_en", rrWrEn, 1'b1);
    checkOutput("same_second_data", rrWrData, 32'h11);
    nextCycle();
    checkOutput("reg7_final", rfModel[7], 32'h11);
    checkOutput("cnt5", rrCnt, 16'd5);

    applyStimulus(1'b1, 5'd8, 32'hA, 1'b1, 5'd9, 32'hB);
    for (int i = 0; i < 20; i++) begin
      #1;
      checkOutput("fp_starve_req1", fpReady1, 1'b0);
      nextCycle();
      if (i == 9) checkOutput("sat_reach15", satCnt, 4'd15);
    end
    checkOutput("sat_hold15", satCnt, 4'd15);
    checkOutput("rr_cnt25", rrCnt, 16'd25);
    checkOutput("pre_rst_wr_en", rrWrEn, 1'b1);

    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready0", rrReady0, 1'b0);
    checkOutput("mid_rst_ready1", rrReady1, 1'b0);
    checkOutput("mid_rst_fp_ready0", fpReady0, 1'b0);
    nextCycle();
    checkOutput("mid_rst_wr_en", rrWrEn, 1'b0);
    checkOutput("mid_rst_wr_addr", rrWrAddr, 5'd0);
    checkOutput("mid_rst_wr_data", rrWrData, 32'h0);
    checkOutput("mid_rst_cnt", rrCnt, 16'd0);
    checkOutput("mid_rst_sat_cnt", satCnt, 4'd0);
    checkOutput("mid_rst_fp_wr_en", fpWrEn, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
